sync_fifo_ctrl_mem: RTL and testbench
=====================================

Name: sync_fifo_ctrl_mem

Overview:
Single-clock, parametrised FIFO combining the storage array with its own pointer, flag and occupancy logic. It is the successor to the bare dual-port FIFO memory. Additions over that memory:
- registered read data with a valid strobe
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow error flags
It is used wherever a producer and consumer share one clock domain.

Parameters:
- data_width, 32, width of each stored word.
- ptr_width, 11, pointer width including the wrap bit; address width is ptr_width-1.
- depth, 1024, number of words; must equal 2**(ptr_width-1).
- afull_thresh, 1020, almost_full asserts when count >= afull_thresh; legal range 1..depth.
- aempty_thresh, 4, almost_empty asserts when count <= aempty_thresh; legal range 0..depth-1.

Ports:
- wclk  input  1  clock; all logic on the rising edge.
- wrst  input  1  reset; synchronous, active-high.
- wen  input  1  write request.
- wdata  input  data_width  write data.
- ren  input  1  read request.
- err_clr  input  1  clears the sticky error flags.
- rdata  output  data_width  registered read data.
- rvalid  output  1  rdata carries a newly read word this cycle.
- full  output  1  FIFO holds depth words.
- empty  output  1  FIFO holds 0 words.
- almost_full  output  1  count >= afull_thresh.
- almost_empty  output  1  count <= aempty_thresh.
- count  output  ptr_width  current occupancy, 0..depth.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (synchronous, sampled on the wclk edge, highest priority over every other input including err_clr):
  - wptr = rptr = 0, rdata = 0, rvalid = 0, overflow = underflow = 0.
  - Memory contents are not cleared.
  - After reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0.
  - Reset asserted mid-operation discards all stored words and any read in flight; rvalid is 0 on the cycle after reset.
- Pointers:
  - wptr and rptr are ptr_width bits wide.
  - The low ptr_width-1 bits address the memory; the MSB is the wrap bit.
  - Both increment modulo 2**ptr_width, so the address wraps from depth-1 to 0 with the MSB toggling.
- Flags:
  - All flags are combinational from the registered pointers, so they reflect accepted operations one cycle after the accepting edge.
  - empty = (wptr == rptr).
  - full = (MSBs differ and low bits equal).
  - count = (wptr - rptr) mod 2**ptr_width.
- Write:
  - Accepted when wen && !full.
  - mem[wptr addr] <= wdata, then wptr+1.
- Read:
  - Accepted when ren && !empty.
  - rdata <= mem[rptr addr], then rptr+1; rvalid = 1 on the following cycle only.
  - Read latency is exactly 1 cycle.
  - rdata holds its last value when no read is accepted; rvalid = 0 in those cycles.
- Simultaneous read and write (full/empty evaluated on pre-edge state, no bypass):
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set; the word becomes readable next cycle.
- Errors:
  - overflow is set on wen && full; underflow is set on ren && empty.
  - Both stay set until err_clr or reset.
  - If a new error event and err_clr occur in the same cycle, the flag remains set (set wins).
  - Rejected operations never modify memory, pointers, rdata or rvalid.
- Thresholds: compared against count, unsigned, full ptr_width width.

Test Plan:
- Reset and fill, with ptr_width=4, depth=8, afull_thresh=6, aempty_thresh=1: assert wrst, write 8 words 0x10..0x17 on consecutive cycles.
  - Required: count steps 1..8; almost_empty drops when count=2; almost_full rises when count=6; full=1 after the 8th write; overflow=0.
- Overflow: with the FIFO full, wen=1 with wdata=0xFF.
  - Required: overflow=1 next cycle; count stays 8; a subsequent drain returns 0x10..0x17, never 0xFF.
- Drain and latency: ren=1 for 9 cycles from full.
  - Required: rvalid pulses 8 times with rdata 0x10..0x17, each exactly 1 cycle after its ren.
  - Required: the 9th ren sets underflow and rdata holds 0x17.
- Wrap-around: after a partial drain, write and read 20 words continuously with ren=wen=1 and count held at 3.
  - Required: data order preserved across pointer wraps; count stays 3; full and empty never assert.
- Simultaneous operations at the boundaries:
  - Empty with ren=wen=1 and wdata=0xA5: underflow=1, count=1, next read returns 0xA5.
  - Full with ren=wen=1: read accepted, count becomes 7, overflow=1.
- err_clr and reset priority:
  - err_clr with no new event clears both flags.
  - err_clr together with wen while full leaves overflow=1.
  - wrst asserted during a read leaves rvalid=0 and count=0 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_ctrl_mem.sv
// sync_fifo_ctrl_mem: single-clock FIFO with its own storage array, wrap-bit
// pointers, occupancy count, programmable almost-full/almost-empty flags,
// registered read data with a valid strobe and sticky overflow/underflow flags.
//
// Handshake semantics:
//   - A write is taken on a rising edge when wen && !full. A read is taken on a
//     rising edge when ren && !empty. full and empty are judged on the state
//     before that edge, and there is no write-to-read bypass.
//   - rvalid is high for exactly the one cycle after an accepted read, and
//     rdata carries that word in that cycle.
//   - A rejected request changes nothing except the matching sticky error flag.
module sync_fifo_ctrl_mem #(
  parameter int data_width    = 32,
  parameter int ptr_width     = 11,
  parameter int depth         = 1024,
  parameter int afull_thresh  = 1020,
  parameter int aempty_thresh = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wen,
  input  logic [data_width-1:0] wdata,
  input  logic                  ren,
  input  logic                  err_clr,
  output logic [data_width-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ptr_width-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int aw = ptr_width - 1;
  localparam logic [ptr_width-1:0] c_afull  = ptr_width'(afull_thresh);
  localparam logic [ptr_width-1:0] c_aempty = ptr_width'(aempty_thresh);
  localparam logic [ptr_width-1:0] c_one    = ptr_width'(1);

  // Storage array. It is deliberately not reset; the pointers define what is
  // valid.
  logic [data_width-1:0] r_mem [depth];

  logic [ptr_width-1:0]  r_wptr;
  logic [ptr_width-1:0]  r_rptr;
  logic [data_width-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [aw-1:0]         w_waddr;
  logic [aw-1:0]         w_raddr;
  logic                  w_full;
  logic                  w_empty;
  logic [ptr_width-1:0]  w_count;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

  // Flags and occupancy are derived combinationally from the registered
  // pointers.
  always_comb begin
    w_waddr     = r_wptr[aw-1:0];
    w_raddr     = r_rptr[aw-1:0];
    w_empty     = (r_wptr == r_rptr);
    w_full      = (r_wptr[aw] != r_rptr[aw]) && (w_waddr == w_raddr);
    w_count     = r_wptr - r_rptr;
    w_wr_accept = wen && !w_full;
    w_rd_accept = ren && !w_empty;
  end

  // Pointer update. Both pointers wrap modulo 2**ptr_width, and the MSB
  // toggles on each pass through the array.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_accept) r_wptr <= r_wptr + c_one;
      if (w_rd_accept) r_rptr <= r_rptr + c_one;
    end
  end

  // Memory write port. Rejected writes never touch the array.
  always_ff @(posedge wclk) begin
    if (!wrst && w_wr_accept) r_mem[w_waddr] <= wdata;
  end

  // Registered read port. rdata holds its value between reads, and rvalid
  // pulses for one cycle.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) r_rdata <= r_mem[w_raddr];
    end
  end

  // Sticky error flags. A new event in the same cycle as err_clr keeps the
  // flag set.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wen && w_full)  || (r_overflow  && !err_clr);
      r_underflow <= (ren && w_empty) || (r_underflow && !err_clr);
    end
  end

  assign rdata        = r_rdata;
  assign rvalid       = r_rvalid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= c_afull);
  assign almost_empty = (w_count <= c_aempty);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl_mem.sv
// tb_sync_fifo_ctrl_mem: directed bench for sync_fifo_ctrl_mem with an
// 8-deep, 8-bit configuration.
module tb_sync_fifo_ctrl_mem;

  localparam int dw = 8;
  localparam int pw = 4;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          wen = 1'b0;
  logic [dw-1:0] wdata = '0;
  logic          ren = 1'b0;
  logic          err_clr = 1'b0;
  logic [dw-1:0] rdata;
  logic          rvalid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [pw-1:0] count;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [dw-1:0] exp_q[$];

  sync_fifo_ctrl_mem #(
    .data_width(dw), .ptr_width(pw), .depth(8),
    .afull_thresh(6), .aempty_thresh(1)
  ) dut (
    .wclk(wclk), .wrst(wrst), .wen(wen), .wdata(wdata), .ren(ren),
    .err_clr(err_clr), .rdata(rdata), .rvalid(rvalid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Clock generation
  always #5 wclk = ~wclk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away
  // from the edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; step(); wrst = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", almost_full); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_errs got %b want 00", {overflow, underflow}); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h want 00", rdata); end
  endtask

  // Fill 0x10..0x17 and walk the threshold flags: aempty for count<=1,
  // afull for count>=6.
  task automatic test_fill();
    logic [pw-1:0] exp_cnt;
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = 8'h10 + 8'(i);
      step();
      exp_cnt = 4'(i + 1);
      n_cmp++; if (count !== exp_cnt) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, exp_cnt); end
      n_cmp++; if (almost_empty !== (exp_cnt <= 4'd1)) begin n_err++; $display("FAIL fill_aempty[%0d] got %b", i, almost_empty); end
      n_cmp++; if (almost_full !== (exp_cnt >= 4'd6)) begin n_err++; $display("FAIL fill_afull[%0d] got %b", i, almost_full); end
      n_cmp++; if (full !== (exp_cnt == 4'd8)) begin n_err++; $display("FAIL fill_full[%0d] got %b", i, full); end
    end
    wen = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    wen = 1'b1; wdata = 8'hFF; step(); wen = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
  endtask

  // Nine reads from full: eight words out with 1-cycle latency, then an
  // underflow on the ninth.
  task automatic test_drain();
    for (int k = 0; k < 9; k++) begin
      ren = 1'b1; step();
      if (k < 8) begin
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL drain_rvalid[%0d] got %b want 1", k, rvalid); end
        n_cmp++; if (rdata !== 8'h10 + 8'(k)) begin n_err++; $display("FAIL drain_rdata[%0d] got %h want %h", k, rdata, 8'h10 + 8'(k)); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL drain_udf[%0d] got %b want 0", k, underflow); end
      end else begin
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL drain_rvalid9 got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 8'h17) begin n_err++; $display("FAIL drain_hold got %h want 17", rdata); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL drain_udf9 got %b want 1", underflow); end
      end
    end
    ren = 1'b0; step();
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL drain_idle_rvalid got %b want 0", rvalid); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drain_ovf_sticky got %b want 1", overflow); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL errclr got %b want 00", {overflow, underflow}); end
  endtask

  // Hold count at 3 with back-to-back read+write for 20 cycles across
  // pointer wraps.
  task automatic test_wrap();
    logic [dw-1:0] exp_d;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = 8'h30 + 8'(i); exp_q.push_back(wdata); step();
    end
    wen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ren = 1'b1; step(); exp_d = exp_q.pop_front();
      n_cmp++; if (rdata !== exp_d || rvalid !== 1'b1) begin n_err++; $display("FAIL wrap_pre[%0d] got %h/%b want %h/1", i, rdata, rvalid, exp_d); end
    end
    for (int i = 0; i < 20; i++) begin
      ren = 1'b1; wen = 1'b1; wdata = 8'h40 + 8'(i);
      step();
      exp_d = exp_q.pop_front(); exp_q.push_back(8'h40 + 8'(i));
      n_cmp++; if (rdata !== exp_d || rvalid !== 1'b1) begin n_err++; $display("FAIL wrap_data[%0d] got %h/%b want %h/1", i, rdata, rvalid, exp_d); end
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 3", i, count); end
      n_cmp++; if (full !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL wrap_flags[%0d] got full=%b empty=%b want 0/0", i, full, empty); end
    end
    wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ren = 1'b1; step(); exp_d = exp_q.pop_front();
      n_cmp++; if (rdata !== exp_d || rvalid !== 1'b1) begin n_err++; $display("FAIL wrap_tail[%0d] got %h/%b want %h/1", i, rdata, rvalid, exp_d); end
    end
    ren = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_end_empty got %b want 1", empty); end
  endtask

  task automatic test_simul_empty();
    ren = 1'b1; wen = 1'b1; wdata = 8'hA5; step(); wen = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL se_udf got %b want 1", underflow); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL se_count got %0d want 1", count); end
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL se_rvalid got %b want 0", rvalid); end
    step(); ren = 1'b0;
    n_cmp++; if (rdata !== 8'hA5 || rvalid !== 1'b1) begin n_err++; $display("FAIL se_read got %h/%b want a5/1", rdata, rvalid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL se_count2 got %0d want 0", count); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL se_clr got %b want 0", underflow); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = 8'h50 + 8'(i); step();
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL sf_prefull got %b want 1", full); end
    ren = 1'b1; wen = 1'b1; wdata = 8'h99; step(); ren = 1'b0; wen = 1'b0;
    n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL sf_count got %0d want 7", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sf_ovf got %b want 1", overflow); end
    n_cmp++; if (rdata !== 8'h50 || rvalid !== 1'b1) begin n_err++; $display("FAIL sf_read got %h/%b want 50/1", rdata, rvalid); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL sf_full got %b want 0", full); end
  endtask

  // A new overflow in the same cycle as err_clr keeps the flag; err_clr alone
  // clears it.
  task automatic test_err_priority();
    wen = 1'b1; wdata = 8'h60; step();
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ep_full got %b want 1", full); end
    wdata = 8'h61; err_clr = 1'b1; step(); wen = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ep_set_wins got %b want 1", overflow); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ep_count got %0d want 8", count); end
    step(); err_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ep_clear got %b want 0", overflow); end
  endtask

  // Reset alongside a read: the read is discarded and the FIFO empties.
  task automatic test_reset_mid_read();
    ren = 1'b1; wrst = 1'b1; err_clr = 1'b0; step(); wrst = 1'b0; ren = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rr_rvalid got %b want 0", rvalid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rr_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rr_empty got %b want 1", empty); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rr_rdata got %h want 00", rdata); end
    step();
    n_cmp++; if (rvalid !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL rr_after got %b/%b want 0/0", rvalid, underflow); end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_err_clr();
    test_wrap();
    test_simul_empty();
    test_simul_full();
    test_err_priority();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
